// File: rtl/axi_lite_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
//   - AXI response codes
//   - write-path FSM state type
//   - clog2 helper used to derive the byte-address LSB
//   - word-index decoder classifying an access as control, status or unmapped
package axi_lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        TGT_CTRL     = 2'd0,
        TGT_STAT     = 2'd1,
        TGT_UNMAPPED = 2'd2
    } tgt_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic tgt_t decode_addr(input int idx, input int num_ctrl, input int num_stat);
        if (idx < num_ctrl) begin
            return TGT_CTRL;
        end
        if (idx < num_ctrl + num_stat) begin
            return TGT_STAT;
        end
        return TGT_UNMAPPED;
    endfunction

endpackage

// File: rtl/axi_lite_regbank_strb_reg.sv
// Single DATA_WIDTH register with per-byte write strobes.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (loads RST_VAL)
//   i_we             write enable for this register (one cycle)
//   i_wdata/i_wstrb  write data and byte-lane enables
//   o_q              current register value
//   o_pulse          high for the cycle after every i_we, regardless of strobes
module axi_lite_regbank_strb_reg
    import axi_lite_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    output logic [DATA_WIDTH-1:0]   o_q,
    output logic                    o_pulse
);

    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q     <= RST_VAL;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= i_we;
            if (i_we) begin
                for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                    if (i_wstrb[k]) begin
                        r_q[k*8 +: 8] <= i_wdata[k*8 +: 8];
                    end
                end
            end
        end
    end

    assign o_q     = r_q;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_CTRL RW control registers followed by
// NUM_STAT RO status registers in the word address map; everything above is
// unmapped. Writes to status or unmapped words get SLVERR with no effect,
// reads of unmapped words return 0 with SLVERR.
// Optional build macro REGBANK_SHADOW_EN: writes land in a shadow copy and
// are transferred to ctrl_o (with wr_pulse_o) on commit_i.
// Ports:
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*       write address, data, response channels
//   S_AXI_AR*/R*          read address and data channels
//   ctrl_o                flattened control register values (reg i at [i*DW +: DW])
//   wr_pulse_o            one-cycle update pulse per control register
//   stat_i                flattened status inputs, synchronous to ACLK
//   commit_i              shadow commit strobe (shadow build only)
//   o_dbg_wr_state        current write FSM state (0 idle, 1 response)
//
// Handshake rule on every channel: a transfer happens on the rising ACLK edge
// where VALID and READY are both high; the source holds VALID and payload
// stable until then, and READY never depends combinationally on VALID.
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int                                DATA_WIDTH = 32,
    parameter int                                ADDR_WIDTH = 8,
    parameter int                                NUM_CTRL   = 4,
    parameter int                                NUM_STAT   = 2,
    parameter logic [NUM_CTRL*DATA_WIDTH-1:0]    CTRL_RST   = '0
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,
    input  logic [ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_CTRL*DATA_WIDTH-1:0]       ctrl_o,
    output logic [NUM_CTRL-1:0]                  wr_pulse_o,
    // kept at least one bit wide so NUM_STAT=0 still elaborates
    input  logic [(NUM_STAT > 0 ? NUM_STAT*DATA_WIDTH : 1)-1:0] stat_i,
    input  logic                                 commit_i,
    output logic                                 o_dbg_wr_state
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    // ---------------- write path ----------------
    wr_state_t             r_wr_state;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_do_write;
    tgt_t w_wr_tgt;

    assign w_aw_hs    = S_AXI_AWVALID && r_awready;
    assign w_w_hs     = S_AXI_WVALID && r_wready;
    assign w_do_write = (r_wr_state == WR_IDLE) && r_aw_held && r_w_held;
    assign w_wr_tgt   = decode_addr(int'(r_aw_idx), NUM_CTRL, NUM_STAT);

    // READY outputs are registered so they are low in reset and rise on the
    // first clock after release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_do_write) begin
                        r_wr_state <= WR_RESP;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= (w_wr_tgt == TGT_CTRL) ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                            r_awready <= 1'b0;
                        end else if (!r_aw_held) begin
                            r_awready <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= S_AXI_WDATA;
                            r_wstrb  <= S_AXI_WSTRB;
                            r_wready <= 1'b0;
                        end else if (!r_w_held) begin
                            r_wready <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_wr_state <= WR_IDLE;
                        r_bvalid   <= 1'b0;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    // ---------------- register array ----------------
    // w_reg_q is what the bus sees: the live registers, or the shadow copy
    // when the shadow build is enabled.
    logic [DATA_WIDTH-1:0] w_reg_q [NUM_CTRL];
    logic [NUM_CTRL-1:0]   w_reg_pulse;

    for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
        logic w_we;
        assign w_we = w_do_write && (w_wr_tgt == TGT_CTRL) && (r_aw_idx == IDX_W'(i));

        axi_lite_regbank_strb_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .RST_VAL    (CTRL_RST[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_reg (
            .i_clk   (ACLK),
            .i_rst_n (ARESETN),
            .i_we    (w_we),
            .i_wdata (r_wdata),
            .i_wstrb (r_wstrb),
            .o_q     (w_reg_q[i]),
            .o_pulse (w_reg_pulse[i])
        );
    end

`ifdef REGBANK_SHADOW_EN
    logic [NUM_CTRL*DATA_WIDTH-1:0] r_ctrl;
    logic [NUM_CTRL-1:0]            r_dirty;
    logic [NUM_CTRL-1:0]            r_pulse;

    // The shadow pulse appears the cycle after its write, so a write that
    // completes on the commit edge is seen here one cycle later and carried
    // to the next commit, while one that completed just before is included.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ctrl  <= CTRL_RST;
            r_dirty <= '0;
            r_pulse <= '0;
        end else if (commit_i) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                r_ctrl[i*DATA_WIDTH +: DATA_WIDTH] <= w_reg_q[i];
            end
            r_pulse <= r_dirty | w_reg_pulse;
            r_dirty <= '0;
        end else begin
            r_pulse <= '0;
            r_dirty <= r_dirty | w_reg_pulse;
        end
    end

    assign ctrl_o     = r_ctrl;
    assign wr_pulse_o = r_pulse;
`else
    for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl_out
        assign ctrl_o[i*DATA_WIDTH +: DATA_WIDTH] = w_reg_q[i];
    end
    assign wr_pulse_o = w_reg_pulse;
`endif

    // ---------------- read path ----------------
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    int                    w_ar_idx;
    tgt_t                  w_rd_tgt;
    logic [DATA_WIDTH-1:0] w_rd_data;

    always_comb begin
        w_ar_idx  = int'(S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);
        w_rd_tgt  = decode_addr(w_ar_idx, NUM_CTRL, NUM_STAT);
        w_rd_data = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_ar_idx == i) begin
                w_rd_data = w_reg_q[i];
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (w_ar_idx == NUM_CTRL + j) begin
                w_rd_data = stat_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else if (r_rvalid) begin
            if (S_AXI_RREADY) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end
        end else if (S_AXI_ARVALID && r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= (w_rd_tgt == TGT_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            r_arready <= 1'b1;
        end
    end

    // ---------------- outputs ----------------
    assign S_AXI_AWREADY  = r_awready;
    assign S_AXI_WREADY   = r_wready;
    assign S_AXI_BVALID   = r_bvalid;
    assign S_AXI_BRESP    = r_bresp;
    assign S_AXI_ARREADY  = r_arready;
    assign S_AXI_RVALID   = r_rvalid;
    assign S_AXI_RDATA    = r_rdata;
    assign S_AXI_RRESP    = r_rresp;
    assign o_dbg_wr_state = r_wr_state;

    // Protection bits and sub-word address bits carry no meaning here.
    logic w_unused;
`ifdef REGBANK_SHADOW_EN
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`else
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, commit_i,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`endif

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed four-register slave used behind the MIPI D-PHY RX control interface.
- Provides NUM_CTRL read/write control registers with byte strobes and NUM_STAT read-only status registers. Out-of-range and read-only writes are answered with SLVERR.
- Sits between the AXI interconnect and the D-PHY/CSI receive datapath.
- Independent AW/W acceptance. One outstanding write and one outstanding read.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 or 64 is legal.
- ADDR_WIDTH, 8, AXI address width; must cover (NUM_CTRL+NUM_STAT)*DATA_WIDTH/8 bytes.
- NUM_CTRL, 4, number of RW control registers; range 1..64.
- NUM_STAT, 2, number of RO status registers; range 0..64.
- CTRL_RST, all zeros, NUM_CTRL*DATA_WIDTH flattened reset values; register i occupies bits [i*DW +: DW].

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  DATA_WIDTH / S_AXI_WSTRB  in  DATA_WIDTH/8
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  ADDR_WIDTH / S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  DATA_WIDTH / S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- ctrl_o  out  NUM_CTRL*DATA_WIDTH  current control register values
- wr_pulse_o  out  NUM_CTRL  one-cycle pulse when register i is updated
- stat_i  in  NUM_STAT*DATA_WIDTH  status inputs, already synchronous to ACLK
- commit_i  in  1  shadow commit strobe; used only with the optional feature

Behaviour:
- Reset is asynchronous and active-low on ARESETN, with a single clock ACLK.
- Reset values: all READY, VALID and RESP outputs are 0; RDATA is 0; wr_pulse_o is 0; ctrl_o is CTRL_RST.
- Word index = ADDR[ADDR_WIDTH-1:ADDR_LSB], where ADDR_LSB = log2(DATA_WIDTH/8). Low address bits are ignored.
- Address map:
  - index < NUM_CTRL: control register (RW).
  - NUM_CTRL <= index < NUM_CTRL+NUM_STAT: status register (RO).
  - anything else: unmapped.
- Write path states: IDLE -> (AW captured and/or W captured) -> RESP.
  - AWREADY is high in IDLE while no address has been captured.
  - WREADY is high in IDLE while no data has been captured.
  - Either channel may complete its handshake first; simultaneous AW and W handshakes in one cycle are accepted.
  - The cycle after both are held, the write is performed and BVALID is asserted. FSM enters RESP with AWREADY=WREADY=0.
  - BVALID and BRESP hold until BREADY; the FSM then returns to IDLE. The next AW/W can be accepted in the cycle after the B handshake.
  - Control target: each byte lane k with WSTRB[k]=1 is updated. BRESP=OKAY. wr_pulse_o[i]=1 in the same cycle BVALID rises, even if WSTRB=0.
  - Status or unmapped target: no state change, no pulse, BRESP=SLVERR (2'b10).
- Read path:
  - ARREADY=1 while RVALID=0.
  - The cycle after the AR handshake, RVALID=1 with registered RDATA. Status values are sampled in the AR handshake cycle.
  - Unmapped target: RDATA=0, RRESP=SLVERR. Otherwise RRESP=OKAY.
  - RDATA and RRESP are held stable until RREADY.
- Read and write paths are fully independent. A read of a register in the same cycle its write completes returns the old value.
- Mid-transaction reset clears all channel state immediately; captured address and data are discarded.

Optional Feature:
- Macro: REGBANK_SHADOW_EN.
- Defined:
  - Writes update a shadow array; reads of control registers return the shadow value.
  - ctrl_o is loaded from the shadow on the cycle after commit_i=1 (e.g. the CSI frame-start).
  - wr_pulse_o fires at commit for every register written since the last commit.
  - A write completing in the same cycle as commit_i lands in the shadow only and is applied at the next commit.
  - Reset loads both the shadow and ctrl_o with CTRL_RST.
- Undefined: commit_i is ignored and writes reach ctrl_o directly as described above.

Decomposition:
- Package axi_lite_regbank_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - write FSM state enum {WR_IDLE, WR_RESP};
  - function clog2 for ADDR_LSB;
  - an address-decode function returning {CTRL, STAT, UNMAPPED}.
- One sub-module, axi_lite_regbank_strb_reg: a single DATA_WIDTH register with byte-strobe write, reset value and write pulse, generated NUM_CTRL times.

Test Plan:
- Reset and basic access: after ARESETN release, write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to offsets 0x0, 0x4, 0x8, 0xC, then read each back. Required: all responses OKAY, data matches, and wr_pulse_o[i] pulses exactly once per write.
- Channel ordering:
  - W leads AW by 3 cycles, then AW leads W by 3 cycles, then both in the same cycle, writing 0x12345678 to offset 0x4.
  - Required: exactly one BVALID per transaction, ctrl_o reg1=0x12345678.
  - Hold BREADY low for 5 cycles. Required: BVALID stays high, AWREADY=WREADY=0.
- Byte strobes: start with reg0=0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101. Required: reg0=0xFF00FF00.
- Status and unmapped access:
  - Drive stat_i reg0=0xCAFE0001 and read offset 0x10. Required: 0xCAFE0001, OKAY.
  - Write offset 0x10. Required: SLVERR, no change.
  - Read 0x40. Required: RDATA=0, SLVERR.
  - Hold RREADY low for 4 cycles. Required: RDATA stable.
- Reset mid-operation: assert ARESETN low after AW captured but before W. Required: all outputs return to reset values asynchronously; a subsequent full write completes normally.
- REGBANK_SHADOW_EN build:
  - Write reg2=0xA5A5A5A5. Required: readback returns 0xA5A5A5A5, ctrl_o unchanged.
  - Pulse commit_i. Required: ctrl_o reg2=0xA5A5A5A5 and wr_pulse_o[2] pulses one cycle later.
